arbitro_rr_4: RTL and testbench

- Round-robin arbiter and sequencer that shares one 4:1 operand multiplexer (32-bit) between four requesters.
- Generates the registered 2-bit mux select and a one-hot grant.
- Registers the selected operand toward the shared downstream resource (ALU or memory port).
- Holds a grant until the resource signals completion, then rotates priority.

---
 rtl/arbitro_rr_4.sv | 110 +++++++++++
 tb/tb_arbitro_rr_4.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/arbitro_rr_4.sv
// Round-robin arbiter sharing one 4:1 operand mux between four requesters.
// Optional forced release after TIMEOUT_CYC busy cycles when ARB_TIMEOUT_EN is defined.
module arbitro_rr_4 #(
  parameter int WIDTH       = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] operando_0,
  input  logic [WIDTH-1:0] operando_1,
  input  logic [WIDTH-1:0] operando_2,
  input  logic [WIDTH-1:0] operando_3,
  input  logic             done,
  output logic [1:0]       control,
  output logic [3:0]       grant,
  output logic             valid,
  output logic [WIDTH-1:0] salida,
  output logic             timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       winner;
  logic [WIDTH-1:0] sel_op;
  logic             drop;
  logic             to_hit;
  logic             release_now;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_param_check
    $error("TIMEOUT_CYC out of range 2..255");
  end

  // Lowest rotated offset wins, so scan offsets from farthest to nearest.
  always_comb begin
    winner = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) winner = ptr + 2'(i);
    end
  end

  always_comb begin
    case (control)
      2'd0:    sel_op = operando_0;
      2'd1:    sel_op = operando_1;
      2'd2:    sel_op = operando_2;
      default: sel_op = operando_3;
    endcase
  end

  assign drop        = ~req[control];
  assign release_now = done | drop | to_hit;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] busy_cnt;

  // Forced release only when neither of the ordinary release causes is present.
  assign to_hit = (state == BUSY) && (busy_cnt == 8'(TIMEOUT_CYC - 1)) && !done && !drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      timeout <= to_hit;
      if (state == BUSY) busy_cnt <= busy_cnt + 8'd1;
      else               busy_cnt <= 8'd0;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      control <= 2'd0;
      grant   <= 4'b0000;
      valid   <= 1'b0;
      salida  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            control <= winner;
            grant   <= 4'b0001 << winner;
            valid   <= 1'b1;
            state   <= BUSY;
          end
        end
        default: begin
          // control and salida keep their last values across the release edge.
          if (release_now) begin
            grant <= 4'b0000;
            valid <= 1'b0;
            state <= IDLE;
            ptr   <= control + 2'd1;
          end else begin
            salida <= sel_op;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_rr_4.sv
// Directed bench for arbitro_rr_4: reset, single grant, fairness, pointer skip,
// simultaneous release, idle done and (with ARB_TIMEOUT_EN) forced release.
module tb_arbitro_rr_4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] operando_0, operando_1, operando_2, operando_3;
  logic        done;
  logic [1:0]  control;
  logic [3:0]  grant;
  logic        valid;
  logic [31:0] salida;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  arbitro_rr_4 #(.WIDTH(32), .TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .operando_0 (operando_0),
    .operando_1 (operando_1),
    .operando_2 (operando_2),
    .operando_3 (operando_3),
    .done       (done),
    .control    (control),
    .grant      (grant),
    .valid      (valid),
    .salida     (salida),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_arb(input string tag, input logic [3:0] g, input logic [1:0] c);
    chk({tag, "_grant"}, 64'(grant), 64'(g));
    chk({tag, "_valid"}, 64'(valid), 64'(|g));
    if (g != 4'b0000) chk({tag, "_control"}, 64'(control), 64'(c));
  endtask

  initial begin
    logic [3:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

    rst_n = 1'b0; req = 4'b0000; done = 1'b0;
    operando_0 = 32'h0; operando_1 = 32'h0; operando_2 = 32'h0; operando_3 = 32'h0;
    step(); step();
    chk_arb("rst", 4'b0000, 2'd0);
    chk("rst_control", 64'(control), 64'd0);
    chk("rst_salida", 64'(salida), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    rst_n = 1'b1;

    // Single requester
    req = 4'b0010; operando_1 = 32'hDEADBEEF;
    step();
    chk_arb("single_grant", 4'b0010, 2'd1);
    step();
    chk("single_salida", 64'(salida), 64'hDEADBEEF);
    operando_1 = 32'hCAFEF00D;
    step();
    chk("single_follow", 64'(salida), 64'hCAFEF00D);
    done = 1'b1;
    step();
    done = 1'b0; req = 4'b0000;
    chk_arb("single_release", 4'b0000, 2'd0);
    chk("single_hold_control", 64'(control), 64'd1);
    chk("single_hold_salida", 64'(salida), 64'hCAFEF00D);
    step();
    chk_arb("single_idle", 4'b0000, 2'd0);

    // ptr=2: grant to 2, then asynchronous reset mid-transaction
    req = 4'b1111;
    operando_0 = 32'hA0A0A0A0; operando_1 = 32'hB1B1B1B1;
    operando_2 = 32'hC2C2C2C2; operando_3 = 32'hD3D3D3D3;
    step();
    chk_arb("pre_rst_grant", 4'b0100, 2'd2);
    step();
    chk("pre_rst_salida", 64'(salida), 64'hC2C2C2C2);
    #2 rst_n = 1'b0;
    #1;
    chk_arb("async_rst", 4'b0000, 2'd0);
    chk("async_rst_control", 64'(control), 64'd0);
    chk("async_rst_salida", 64'(salida), 64'd0);
    rst_n = 1'b1;
    step();
    chk_arb("post_rst_grant", 4'b0001, 2'd0);

    // Fairness with all requests held
    for (int k = 0; k < 4; k++) begin
      step();
      case (k)
        0: chk("rr_salida0", 64'(salida), 64'hA0A0A0A0);
        1: chk("rr_salida1", 64'(salida), 64'hB1B1B1B1);
        2: chk("rr_salida2", 64'(salida), 64'hC2C2C2C2);
        default: chk("rr_salida3", 64'(salida), 64'hD3D3D3D3);
      endcase
      done = 1'b1;
      step();
      done = 1'b0;
      chk_arb("rr_idle", 4'b0000, 2'd0);
      step();
      chk_arb("rr_grant", exp_g[k+1], 2'((k + 1) % 4));
    end

    // Release grant 0 -> ptr=1, then grant to 2 alone
    step();
    done = 1'b1;
    step();
    done = 1'b0; req = 4'b0100;
    chk_arb("skip_rel0", 4'b0000, 2'd0);
    step();
    chk_arb("skip_grant2", 4'b0100, 2'd2);
    req = 4'b0101; done = 1'b1;
    step();
    done = 1'b0;
    chk_arb("skip_rel2", 4'b0000, 2'd0);
    step();
    chk_arb("skip_wrap_grant0", 4'b0001, 2'd0);

    // Simultaneous done and withdrawal: one release, ptr -> 1
    step();
    req = 4'b0100; done = 1'b1;
    step();
    done = 1'b0; req = 4'b1111;
    chk_arb("simul_release", 4'b0000, 2'd0);
    chk("simul_timeout", 64'(timeout), 64'd0);
    step();
    chk_arb("simul_next", 4'b0010, 2'd1);
    chk("simul_timeout2", 64'(timeout), 64'd0);

    // done in IDLE leaves ptr at 2
    step();
    done = 1'b1;
    step();
    req = 4'b0000;
    chk_arb("idle_rel", 4'b0000, 2'd0);
    step();
    done = 1'b0;
    step();
    chk_arb("idle_done_ignored", 4'b0000, 2'd0);
    req = 4'b1111;
    step();
    chk_arb("idle_done_next", 4'b0100, 2'd2);

`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      step();
      chk_arb("to_hold", 4'b0100, 2'd2);
      chk("to_hold_timeout", 64'(timeout), 64'd0);
    end
    step();
    chk_arb("to_release", 4'b0000, 2'd0);
    chk("to_pulse", 64'(timeout), 64'd1);
    step();
    chk("to_pulse_end", 64'(timeout), 64'd0);
    chk_arb("to_next_from3", 4'b1000, 2'd3);
`else
    for (int k = 0; k < 10; k++) begin
      step();
      chk_arb("no_to_hold", 4'b0100, 2'd2);
      chk("no_to_timeout", 64'(timeout), 64'd0);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    chk_arb("no_to_release", 4'b0000, 2'd0);
    step();
    chk_arb("no_to_next", 4'b1000, 2'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
